ecg_sample_player: RTL

Synthesizable, parametrised ECG sample source for the QRS detection chain. It replaces file-driven stimulus with an on-chip sample memory that is loaded through a write port. The memory is played out at a programmable sample rate, in one-shot or loop mode, with pause and abort control. Its output `xout` feeds the `xin` input of `top` in hardware-in-the-loop and self-test builds.

---
 rtl/ecg_sample_player.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ecg_sample_player.sv
// ecg_sample_player
// -----------------------------------------------------------------------------
// On-chip ECG sample source. Samples are loaded through a write port into a
// 2^ADDR_WIDTH deep memory. They are then played out at a programmable rate,
// either once or in a loop, with pause (en) and abort control. xout drives
// the xin input of the QRS detection top in HIL and self-test builds.
//
// Ports:
//   clk         system clock, rising edge
//   rstn        asynchronous active-low reset
//   en          global enable; 0 freezes the FSM, divider and output pipeline
//   wr_en       memory write strobe (honoured in every state, even with en=0)
//   wr_addr     write address
//   wr_data     write sample (signed)
//   start       start-playback pulse (IDLE/DONE only, needs en=1)
//   abort       stop-playback pulse (needs en=1, wins over start)
//   loop        1 = wrap to address 0 after the last sample
//   len_m1      record length minus one
//   rate_div    one sample every rate_div+1 enabled cycles
//   xout        played sample (signed, registered)
//   xout_valid  one-cycle strobe: a new sample is on xout
//   sample_idx  memory address of the sample currently on xout
//   busy        playback in progress
//   done        one-shot record finished (level, cleared by start or abort)
//
// Output handshake: there is no ready; the consumer must take xout whenever
// xout_valid is high. xout and sample_idx hold their value between strobes.
// -----------------------------------------------------------------------------
module ecg_sample_player #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         loop,
    input  logic [ADDR_WIDTH-1:0]        len_m1,
    input  logic [DIV_WIDTH-1:0]         rate_div,
    output logic signed [DATA_WIDTH-1:0] xout,
    output logic                         xout_valid,
    output logic [ADDR_WIDTH-1:0]        sample_idx,
    output logic                         busy,
    output logic                         done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_WIDTH-1:0]  DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Parameters latched at start; the live inputs are ignored during PLAY.
    logic [ADDR_WIDTH-1:0] len_l;
    logic [DIV_WIDTH-1:0]  div_l;
    logic                  loop_l;

    logic [DIV_WIDTH-1:0]  div_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Read stage: data is valid one cycle after the tick that issued it.
    logic signed [DATA_WIDTH-1:0] rd_data;
    logic                         rd_valid;
    logic [ADDR_WIDTH-1:0]        rd_idx;
    logic                         rd_last;

    logic signed [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic go;
    logic stop;
    logic tick;
    logic at_end;
    logic emit;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        stop      = 1'b0;
        tick      = 1'b0;
        at_end    = (rd_addr == len_l);
        if (en) begin
            if (abort) begin
                stop      = 1'b1;
                state_nxt = IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            go        = 1'b1;
                            state_nxt = PLAY;
                        end
                    end
                    PLAY: begin
                        if (div_cnt == div_l) begin
                            tick = 1'b1;
                            if (at_end && !loop_l) begin
                                state_nxt = DONE;
                            end
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // An abort discards whatever the read stage holds.
    assign emit = rd_valid && !stop;

    // ---------------------------------------------------------------- memory
    // Read-first: a same-address write in the tick cycle returns old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (tick) begin
            rd_data <= mem[rd_addr];
        end
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_l      <= '0;
            div_l      <= '0;
            loop_l     <= 1'b0;
            div_cnt    <= '0;
            rd_addr    <= '0;
            rd_valid   <= 1'b0;
            rd_idx     <= '0;
            rd_last    <= 1'b0;
            xout       <= '0;
            xout_valid <= 1'b0;
            sample_idx <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (en) begin
            // Output stage
            xout_valid <= emit;
            if (emit) begin
                xout       <= rd_data;
                sample_idx <= rd_idx;
                // The final one-shot sample and the done/busy change share an edge.
                if (rd_last) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end

            // Read stage
            rd_valid <= tick;
            rd_last  <= tick && at_end && !loop_l;
            if (tick) begin
                rd_idx <= rd_addr;
            end

            if (stop) begin
                busy <= 1'b0;
                done <= 1'b0;
            end

            // Divider and address
            if (go) begin
                len_l   <= len_m1;
                div_l   <= rate_div;
                loop_l  <= loop;
                rd_addr <= '0;
                div_cnt <= '0;
                done    <= 1'b0;
                busy    <= 1'b1;
            end else if (tick) begin
                div_cnt <= '0;
                rd_addr <= at_end ? '0 : rd_addr + ADDR_ONE;
            end else if (state == PLAY) begin
                div_cnt <= div_cnt + DIV_ONE;
            end
        end else begin
            // Paused: everything holds, only the strobe is suppressed.
            xout_valid <= 1'b0;
        end
    end

endmodule
